cmd_fifo: RTL and testbench
===========================

# cmd_fifo

Instruction front end of the 2D GPU. Accepts 32-bit host words and assembles each group of three into one 82-bit draw/alpha instruction. Buffers the instructions in a DEPTH-entry FIFO and presents them show-ahead to the `overall` controller on `fifo_data`/`fifo_empty`. `overall` pops an entry by pulsing `fifo_read` once it has latched the instruction.

## Interface
Parameters:
- `DEPTH`, default 8: FIFO entries. Must be a power of two, ≥ 2.
- `AF_THRESH`, default 6: almost-full threshold, used only under `CMD_FIFO_ALMOST_FULL_EN`.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `host_wdata` in 32: host instruction word.
- `host_wvalid` in 1: host word valid.
- `host_wready` out 1: word accepted on an edge where `host_wvalid && host_wready`.
- `host_flush` in 1: synchronous clear of the assembler, FIFO and error flag.
- `fifo_read` in 1: pop strobe from `overall`.
- `fifo_data` out 82: head entry, packed as {alpha_val[3:0], texture_code[1:0], color_code[23:0], fill_type, layer_num, y2, x2, y1, x1, y0, x0 (8 b each), vertice_num, inst_type}.
- `fifo_empty` out 1: no valid head entry.
- `fifo_count` out $clog2(DEPTH)+1: number of stored entries.
- `underflow_err` out 1: sticky; set by `fifo_read` while `fifo_empty`.
- `almost_full` out 1: present only with `CMD_FIFO_ALMOST_FULL_EN`.

## Operation
- **Assembler FSM**, states W0 → W1 → W2 → W0. It advances one state per accepted word.
  - W0: `host_wdata` is written to shadow bits [31:0].
  - W1: `host_wdata` is written to shadow bits [63:32].
  - W2: `host_wdata[17:0]` forms bits [81:64]; `host_wdata[31:18]` are ignored.
  - The accepted word in W2 pushes {word2[17:0], shadow[63:0]} into the FIFO.
- **`host_wready`** is 1 in W0 and W1. In W2 it equals `!full`. The host is therefore only stalled on the word that would push. There is no same-cycle pop-to-full bypass.
- **FIFO storage** is a circular buffer with `rd_ptr`/`wr_ptr` of $clog2(DEPTH) bits that wrap modulo DEPTH, plus a count register.
  - `full` is `count == DEPTH`.
  - `fifo_empty` is `count == 0`.
- **Pop**: `fifo_read && !fifo_empty` increments `rd_ptr` and decrements count.
- **Ignored pop**: `fifo_read && fifo_empty` changes no state and sets `underflow_err`.
- **Simultaneous push and pop** with count in 1..DEPTH-1: both happen and count is unchanged.
- **Push with pop while empty**: the push happens, the pop is ignored, and `underflow_err` is set.
- **`host_flush`**: the assembler returns to W0 and partial words are discarded. Pointers and count go to 0 and `underflow_err` is cleared. It takes priority over a push or pop in the same cycle.
- **Instruction contents**: no decoding or validation. `inst_type` and `vertice_num` are opaque to this block.

## Timing
- Reset values:
  - `fifo_empty` = 1
  - `fifo_count` = 0
  - `underflow_err` = 0
  - `host_wready` = 1, assembler in W0
  - `fifo_data` = 0 (memory is cleared on reset)
  - `almost_full` = 0
- Push latency: the third word is accepted at edge N. From edge N, `fifo_empty` = 0 and `fifo_data` shows the entry. It is visible to `overall` in the cycle after acceptance.
- `fifo_data` is a combinational read of `mem[rd_ptr]`. After a pop at edge N, the next entry is valid immediately after edge N.
- `fifo_read` is level-sampled. Each cycle it is high pops one entry, so `overall` must pulse it for exactly one cycle per instruction.
- Reset asserted mid-operation clears everything asynchronously, including a partially assembled instruction. On release, the first accepted word is treated as W0.

## Configuration
- `CMD_FIFO_ALMOST_FULL_EN` defined:
  - Adds the `almost_full` output, registered.
  - `almost_full` = 1 when the next-state count is ≥ AF_THRESH, so it is updated on the same edge as count.
- `CMD_FIFO_ALMOST_FULL_EN` undefined: the port and its logic are absent.

## Structure
- Package `gpu_pkg` holds:
  - `INST_W` = 82
  - `HOST_W` = 32
  - packed struct `inst_t` with the field order above
  - enum `asm_state_t` {W0, W1, W2}
- Sub-module `cmd_assembler` holds the FSM, shadow register and push strobe. `cmd_fifo` holds the pointers, count, memory and flags.

## Test plan
- **Single instruction**: three words encoding x0=200, y0=200, x1=220, y1=220, x2=180, y2=180, color=FFEEDD, vertice_num=1, inst_type=0 → `fifo_empty` falls after the third accept; `fifo_data` fields match exactly; `fifo_count`=1.
- **Fill to full**: push DEPTH instructions, then offer three more words → `host_wready` = 0 only in W2; count = DEPTH. One pop → the stalled push completes the next cycle.
- **Ordering and wrap**: push/pop 3×DEPTH distinct instructions (color = index) → output order is preserved across pointer wrap.
- **Simultaneous push and pop** at count=2 → count stays 2 and head advances. Push and pop at count=0 → count=1 and `underflow_err`=1.
- **Flush mid-assembly**: flush after word W1 → state W0, count 0, and the next three words form a clean instruction. Async `rst` mid-stream → all outputs return to reset values.
- **Almost-full** (`CMD_FIFO_ALMOST_FULL_EN`): `almost_full` rises on the edge where count reaches 6 and falls when a pop brings count to 5.

Source files
------------

// File: rtl/gpu_pkg.sv
// gpu_pkg: shared widths, instruction layout and assembler states for the GPU front end
package gpu_pkg;
  localparam int INST_W = 82;
  localparam int HOST_W = 32;
  typedef struct packed {
    logic [3:0]  alpha_val;
    logic [1:0]  texture_code;
    logic [23:0] color_code;
    logic        fill_type;
    logic        layer_num;
    logic [7:0]  y2;
    logic [7:0]  x2;
    logic [7:0]  y1;
    logic [7:0]  x1;
    logic [7:0]  y0;
    logic [7:0]  x0;
    logic        vertice_num;
    logic        inst_type;
  } inst_t;
  typedef enum logic [1:0] {W0, W1, W2} asm_state_t;
endpackage

// File: rtl/cmd_fifo_if.sv
// cmd_fifo_if: host write port and overall-side read port of cmd_fifo (almost_full under CMD_FIFO_ALMOST_FULL_EN)
interface cmd_fifo_if #(parameter int DEPTH = 8);
  import gpu_pkg::*;
  logic [HOST_W-1:0]        host_wdata;
  logic                     host_wvalid;
  logic                     host_wready;
  logic                     host_flush;
  logic                     fifo_read;
  logic [INST_W-1:0]        fifo_data;
  logic                     fifo_empty;
  logic [$clog2(DEPTH):0]   fifo_count;
  logic                     underflow_err;
`ifdef CMD_FIFO_ALMOST_FULL_EN
  logic                     almost_full;
`endif
  modport slave (
    input  host_wdata, host_wvalid, host_flush, fifo_read,
    output host_wready, fifo_data, fifo_empty, fifo_count, underflow_err
`ifdef CMD_FIFO_ALMOST_FULL_EN
    , output almost_full
`endif
  );
  modport master (
    output host_wdata, host_wvalid, host_flush, fifo_read,
    input  host_wready, fifo_data, fifo_empty, fifo_count, underflow_err
`ifdef CMD_FIFO_ALMOST_FULL_EN
    , input almost_full
`endif
  );
endinterface

// File: rtl/cmd_assembler.sv
// cmd_assembler: gathers three host words into one instruction and strobes a push on the third
module cmd_assembler
  import gpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic [HOST_W-1:0] i_wdata,
  input  logic              i_wvalid,
  input  logic              i_full,
  output logic              o_wready,
  output logic              o_push,
  output logic [INST_W-1:0] o_inst
);
  asm_state_t  r_state;
  logic [63:0] r_shadow;
  logic        w_acc;
  // only the pushing word can be stalled by a full FIFO
  always_comb begin
    o_wready = (r_state != W2) || !i_full;
    w_acc    = i_wvalid && o_wready;
    o_push   = w_acc && (r_state == W2) && !i_flush;
    o_inst   = {i_wdata[17:0], r_shadow};
  end
  // state advances per accepted word; flush drops any partial instruction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= W0;
      r_shadow <= '0;
    end else if (i_flush) begin
      r_state  <= W0;
      r_shadow <= '0;
    end else if (w_acc) begin
      case (r_state)
        W0:      begin r_shadow[31:0]  <= i_wdata; r_state <= W1; end
        W1:      begin r_shadow[63:32] <= i_wdata; r_state <= W2; end
        default: r_state <= W0;
      endcase
    end
  end
endmodule

// File: rtl/cmd_fifo.sv
// cmd_fifo: host word assembler feeding a show-ahead instruction FIFO; CMD_FIFO_ALMOST_FULL_EN adds almost_full
module cmd_fifo
  import gpu_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = 6
) (
  input logic        clk,
  input logic        rst,
  cmd_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  logic [INST_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_rd, r_wr;
  logic [AW:0]       r_cnt, w_cnt_nxt;
  logic              r_uerr, w_full, w_empty, w_push, w_pop;
  logic [INST_W-1:0] w_inst;
  if ((DEPTH & (DEPTH - 1)) != 0 || DEPTH < 2 || AF_THRESH > DEPTH) begin : g_bad_cfg
    $error("cmd_fifo: DEPTH must be a power of two >= 2 and AF_THRESH <= DEPTH");
  end
  cmd_assembler u_asm (
    .clk      (clk),
    .rst      (rst),
    .i_flush  (bus.host_flush),
    .i_wdata  (bus.host_wdata),
    .i_wvalid (bus.host_wvalid),
    .i_full   (w_full),
    .o_wready (bus.host_wready),
    .o_push   (w_push),
    .o_inst   (w_inst)
  );
  // flags, pop qualification and next count
  always_comb begin
    w_full    = r_cnt == (AW+1)'(DEPTH);
    w_empty   = r_cnt == '0;
    w_pop     = bus.fifo_read && !w_empty;
    w_cnt_nxt = r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    bus.fifo_data     = r_mem[r_rd];
    bus.fifo_empty    = w_empty;
    bus.fifo_count    = r_cnt;
    bus.underflow_err = r_uerr;
  end
  // circular buffer; flush clears pointers and flags but leaves memory contents
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_rd   <= '0;
      r_wr   <= '0;
      r_cnt  <= '0;
      r_uerr <= 1'b0;
    end else if (bus.host_flush) begin
      r_rd   <= '0;
      r_wr   <= '0;
      r_cnt  <= '0;
      r_uerr <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= w_inst;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      if (bus.fifo_read && w_empty) r_uerr <= 1'b1;
      r_cnt <= w_cnt_nxt;
    end
  end
`ifdef CMD_FIFO_ALMOST_FULL_EN
  logic r_af;
  // registered from next count so it moves on the same edge as fifo_count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_af <= 1'b0;
    else if (bus.host_flush) r_af <= 1'b0;
    else r_af <= w_cnt_nxt >= (AW+1)'(AF_THRESH);
  end
  assign bus.almost_full = r_af;
`endif
endmodule

// File: tb/tb_cmd_fifo.sv
// tb_cmd_fifo: table vectors plus scoreboard queue checking cmd_fifo ordering, stalls, flush and reset
module tb_cmd_fifo;
  import gpu_pkg::*;
  localparam int DEPTH = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  inst_t q[$];
  cmd_fifo_if #(.DEPTH(DEPTH)) bus ();
  cmd_fifo #(.DEPTH(DEPTH), .AF_THRESH(6)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {
    inst_t inst;
    int    exp_cnt;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string nm, input logic [81:0] act, input logic [81:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic inst_t mk(input int idx);
    inst_t t;
    t = '0;
    t.x0 = 8'($urandom); t.y0 = 8'($urandom);
    t.x1 = 8'($urandom); t.y1 = 8'($urandom);
    t.x2 = 8'($urandom); t.y2 = 8'($urandom);
    t.alpha_val = 4'($urandom);
    t.texture_code = 2'($urandom);
    t.fill_type = 1'($urandom);
    t.layer_num = 1'($urandom);
    t.vertice_num = 1'($urandom);
    t.inst_type = 1'($urandom);
    t.color_code = 24'(idx);
    return t;
  endfunction

  function automatic logic [31:0] word(input inst_t t, input int n);
    logic [81:0] v;
    v = t;
    return n == 0 ? v[31:0] : n == 1 ? v[63:32] : {14'h3fff, v[81:64]};
  endfunction

  task automatic send_word(input logic [31:0] w);
    int n;
    n = 0;
    bus.host_wdata = w;
    bus.host_wvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.host_wready) break;
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL send_word timeout act=wready0 exp=wready1");
        bus.host_wvalid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1 bus.host_wvalid = 1'b0;
  endtask

  task automatic send_inst(input inst_t t);
    for (int i = 0; i < 3; i++) send_word(word(t, i));
    q.push_back(t);
  endtask

  task automatic pop_chk(input string nm);
    inst_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard empty act=pop exp=none", nm);
      return;
    end
    e = q.pop_front();
    @(negedge clk);
    chk(nm, bus.fifo_data, e);
    bus.fifo_read = 1'b1;
    @(posedge clk);
    #1 bus.fifo_read = 1'b0;
  endtask

  task automatic drain(input string nm);
    while (q.size() > 0) pop_chk(nm);
    chk({nm, "_empty"}, 82'(bus.fifo_empty), 82'(1));
  endtask

  task automatic flush();
    bus.host_flush = 1'b1;
    @(posedge clk);
    #1 bus.host_flush = 1'b0;
    q.delete();
  endtask

  initial begin
    inst_t s;
    bus.host_wdata = '0;
    bus.host_wvalid = 1'b0;
    bus.host_flush = 1'b0;
    bus.fifo_read = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_empty", 82'(bus.fifo_empty), 82'(1));
    chk("rst_count", 82'(bus.fifo_count), 82'(0));
    chk("rst_uerr", 82'(bus.underflow_err), 82'(0));
    chk("rst_wready", 82'(bus.host_wready), 82'(1));
    chk("rst_data", bus.fifo_data, 82'(0));
`ifdef CMD_FIFO_ALMOST_FULL_EN
    chk("rst_af", 82'(bus.almost_full), 82'(0));
`endif
    rst = 1'b0;
    @(posedge clk);
    #1;
    s = '0;
    s.x0 = 8'd200; s.y0 = 8'd200; s.x1 = 8'd220; s.y1 = 8'd220;
    s.x2 = 8'd180; s.y2 = 8'd180; s.color_code = 24'hFFEEDD;
    s.vertice_num = 1'b1; s.inst_type = 1'b0;
    send_word(word(s, 0));
    send_word(word(s, 1));
    chk("single_empty_before", 82'(bus.fifo_empty), 82'(1));
    send_word(word(s, 2));
    q.push_back(s);
    chk("single_empty_after", 82'(bus.fifo_empty), 82'(0));
    chk("single_count", 82'(bus.fifo_count), 82'(1));
    chk("single_x1", 82'(bus.fifo_data[25:18]), 82'(220));
    chk("single_color", 82'(bus.fifo_data[75:52]), 82'(24'hFFEEDD));
    drain("single_pop");
    for (int i = 0; i < 5; i++) tbl[i] = '{mk(100 + i), i + 1};
    for (int i = 0; i < 5; i++) begin
      send_inst(tbl[i].inst);
      chk($sformatf("tbl_count%0d", i), 82'(bus.fifo_count), 82'(tbl[i].exp_cnt));
    end
    drain("tbl_pop");
    for (int i = 0; i < DEPTH; i++) send_inst(mk(200 + i));
    chk("full_count", 82'(bus.fifo_count), 82'(DEPTH));
    s = mk(300);
    send_word(word(s, 0));
    send_word(word(s, 1));
    chk("full_partial_count", 82'(bus.fifo_count), 82'(DEPTH));
    bus.host_wdata = word(s, 2);
    bus.host_wvalid = 1'b1;
    @(negedge clk);
    chk("full_stall_wready", 82'(bus.host_wready), 82'(0));
    chk("full_head", bus.fifo_data, q.pop_front());
    q.push_back(s);
    bus.fifo_read = 1'b1;
    @(posedge clk);
    #1 bus.fifo_read = 1'b0;
    chk("full_after_pop", 82'(bus.fifo_count), 82'(DEPTH - 1));
    @(negedge clk);
    chk("full_wready_resume", 82'(bus.host_wready), 82'(1));
    @(posedge clk);
    #1 bus.host_wvalid = 1'b0;
    chk("full_refill", 82'(bus.fifo_count), 82'(DEPTH));
    drain("full_drain");
    for (int i = 0; i < 3 * DEPTH; i++) begin
      send_inst(mk(i));
      if (q.size() >= 5) pop_chk("wrap");
    end
    drain("wrap_drain");
    send_inst(mk(400));
    send_inst(mk(401));
    s = mk(402);
    send_word(word(s, 0));
    send_word(word(s, 1));
    bus.host_wdata = word(s, 2);
    bus.host_wvalid = 1'b1;
    bus.fifo_read = 1'b1;
    @(negedge clk);
    chk("pp2_head", bus.fifo_data, q.pop_front());
    q.push_back(s);
    @(posedge clk);
    #1;
    bus.host_wvalid = 1'b0;
    bus.fifo_read = 1'b0;
    chk("pp2_count", 82'(bus.fifo_count), 82'(2));
    chk("pp2_next", bus.fifo_data, q[0]);
    drain("pp2_drain");
    s = mk(500);
    send_word(word(s, 0));
    send_word(word(s, 1));
    bus.host_wdata = word(s, 2);
    bus.host_wvalid = 1'b1;
    bus.fifo_read = 1'b1;
    @(posedge clk);
    #1;
    bus.host_wvalid = 1'b0;
    bus.fifo_read = 1'b0;
    q.push_back(s);
    chk("pp0_count", 82'(bus.fifo_count), 82'(1));
    chk("pp0_uerr", 82'(bus.underflow_err), 82'(1));
    drain("pp0_drain");
    bus.fifo_read = 1'b1;
    @(posedge clk);
    #1 bus.fifo_read = 1'b0;
    chk("ign_count", 82'(bus.fifo_count), 82'(0));
    chk("ign_uerr", 82'(bus.underflow_err), 82'(1));
    flush();
    chk("flush_uerr", 82'(bus.underflow_err), 82'(0));
    send_inst(mk(600));
    s = mk(601);
    send_word(word(s, 0));
    send_word(word(s, 1));
    flush();
    chk("flush_count", 82'(bus.fifo_count), 82'(0));
    chk("flush_empty", 82'(bus.fifo_empty), 82'(1));
    s = mk(602);
    send_inst(s);
    chk("flush_clean", bus.fifo_data, s);
    drain("flush_drain");
    send_inst(mk(700));
    bus.fifo_read = 1'b1;
    send_word(word(mk(701), 0));
    bus.fifo_read = 1'b0;
    bus.fifo_read = 1'b1;
    @(posedge clk);
    #1 bus.fifo_read = 1'b0;
    chk("pre_rst_uerr", 82'(bus.underflow_err), 82'(1));
    send_word(word(mk(702), 0));
    rst = 1'b1;
    #1;
    chk("arst_empty", 82'(bus.fifo_empty), 82'(1));
    chk("arst_count", 82'(bus.fifo_count), 82'(0));
    chk("arst_uerr", 82'(bus.underflow_err), 82'(0));
    chk("arst_wready", 82'(bus.host_wready), 82'(1));
    chk("arst_data", bus.fifo_data, 82'(0));
    q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    s = mk(703);
    send_inst(s);
    chk("arst_clean", bus.fifo_data, s);
    drain("arst_drain");
`ifdef CMD_FIFO_ALMOST_FULL_EN
    for (int i = 0; i < 5; i++) send_inst(mk(800 + i));
    chk("af_at5", 82'(bus.almost_full), 82'(0));
    send_inst(mk(805));
    chk("af_at6", 82'(bus.almost_full), 82'(1));
    pop_chk("af_pop");
    chk("af_back5", 82'(bus.almost_full), 82'(0));
    chk("af_count5", 82'(bus.fifo_count), 82'(5));
    drain("af_drain");
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
